// File: rtl/plru_state_ctrl_if.sv
// Lookup, hit-touch and fill-touch bundle for the tree-PLRU state store.
// The slave modport is the replacement controller; the master is the cache pipeline.
interface plru_state_ctrl_if #(
  parameter int unsigned WAY_CNT = 4,
  parameter int unsigned SET_CNT = 64
);
  localparam int unsigned SET_W = (SET_CNT > 1) ? $clog2(SET_CNT) : 1;

  logic               lookup_valid_i;
  logic [SET_W-1:0]   lookup_set_i;
  logic [WAY_CNT-1:0] way_valid_i;
  logic               victim_valid_o;
  logic [WAY_CNT-1:0] victim_way_o;
  logic               hit_valid_i;
  logic [SET_W-1:0]   hit_set_i;
  logic [WAY_CNT-1:0] hit_way_i;
  logic               fill_valid_i;
  logic [SET_W-1:0]   fill_set_i;
  logic [WAY_CNT-1:0] fill_way_i;

  modport slave (
    input  lookup_valid_i, lookup_set_i, way_valid_i,
    input  hit_valid_i, hit_set_i, hit_way_i,
    input  fill_valid_i, fill_set_i, fill_way_i,
    output victim_valid_o, victim_way_o
  );

  modport master (
    output lookup_valid_i, lookup_set_i, way_valid_i,
    output hit_valid_i, hit_set_i, hit_way_i,
    output fill_valid_i, fill_set_i, fill_way_i,
    input  victim_valid_o, victim_way_o
  );
endinterface

// File: rtl/plru_state_ctrl.sv
// Per-set tree-PLRU state store with one-cycle victim lookup and chained hit/fill touches.
// Optional build macro PLRU_INVALID_FIRST_EN: pick the lowest invalid way before the tree walk.
module tree_lru_update #(
  parameter int unsigned WAY_CNT = 4
) (
  input  logic [WAY_CNT-1:1] i_tree,
  input  logic               i_valid,
  input  logic [WAY_CNT-1:0] i_way,
  output logic [WAY_CNT-1:1] o_tree
);
  localparam int unsigned LVL = $clog2(WAY_CNT);

  typedef logic [WAY_CNT-1:1] tree_t;

  function automatic int unsigned node_depth(int unsigned n);
    int unsigned d;
    int unsigned k;
    d = 0;
    k = n;
    while (k > 1) begin
      k = k >> 1;
      d++;
    end
    return d;
  endfunction

  // Nodes on the root-to-leaf path of way w.
  function automatic tree_t path_mask(int unsigned w);
    tree_t       m;
    int unsigned leaf;
    m    = '0;
    leaf = w + WAY_CNT;
    for (int unsigned n = 1; n < WAY_CNT; n++) begin
      m[n] = ((leaf >> (LVL - node_depth(n))) == n);
    end
    return m;
  endfunction

  // Set where way w sits in the node's upper half.
  function automatic tree_t dir_bits(int unsigned w);
    tree_t       m;
    int unsigned leaf;
    m    = '0;
    leaf = w + WAY_CNT;
    for (int unsigned n = 1; n < WAY_CNT; n++) begin
      m[n] = ((leaf >> (LVL - node_depth(n) - 1)) == (2 * n + 1));
    end
    return m;
  endfunction

  tree_t w_path [WAY_CNT];
  tree_t w_dir  [WAY_CNT];
  tree_t w_path_sel;
  tree_t w_dir_sel;

  for (genvar w = 0; w < WAY_CNT; w++) begin : g_way
    localparam tree_t PathMask = path_mask(w);
    localparam tree_t DirBits  = dir_bits(w);
    assign w_path[w] = i_way[w] ? PathMask : '0;
    assign w_dir[w]  = i_way[w] ? DirBits  : '0;
  end

  always_comb begin
    w_path_sel = '0;
    w_dir_sel  = '0;
    for (int w = 0; w < WAY_CNT; w++) begin
      w_path_sel = w_path_sel | w_path[w];
      w_dir_sel  = w_dir_sel | w_dir[w];
    end
  end

  // Path nodes point away from the touched way; an empty way vector leaves the tree as is.
  assign o_tree = i_valid ? ((i_tree & ~w_path_sel) | (~w_dir_sel & w_path_sel)) : i_tree;
endmodule

module plru_state_ctrl #(
  parameter int unsigned WAY_CNT = 4,
  parameter int unsigned SET_CNT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  plru_state_ctrl_if.slave bus
);
  localparam int unsigned SET_W = (SET_CNT > 1) ? $clog2(SET_CNT) : 1;
  localparam int unsigned LVL   = $clog2(WAY_CNT);

  typedef logic [WAY_CNT-1:1] tree_t;

  function automatic int unsigned node_depth(int unsigned n);
    int unsigned d;
    int unsigned k;
    d = 0;
    k = n;
    while (k > 1) begin
      k = k >> 1;
      d++;
    end
    return d;
  endfunction

  function automatic tree_t path_mask(int unsigned w);
    tree_t       m;
    int unsigned leaf;
    m    = '0;
    leaf = w + WAY_CNT;
    for (int unsigned n = 1; n < WAY_CNT; n++) begin
      m[n] = ((leaf >> (LVL - node_depth(n))) == n);
    end
    return m;
  endfunction

  function automatic tree_t dir_bits(int unsigned w);
    tree_t       m;
    int unsigned leaf;
    m    = '0;
    leaf = w + WAY_CNT;
    for (int unsigned n = 1; n < WAY_CNT; n++) begin
      m[n] = ((leaf >> (LVL - node_depth(n) - 1)) == (2 * n + 1));
    end
    return m;
  endfunction

  tree_t              r_state [SET_CNT];
  logic               r_lkp_valid;
  logic [SET_W-1:0]   r_lkp_set;

  tree_t              w_hit_cur;
  tree_t              w_hit_new;
  tree_t              w_fill_cur;
  tree_t              w_fill_new;
  logic               w_same_set;
  tree_t              w_lkp_tree;
  logic [WAY_CNT-1:0] w_walk_way;
  logic [WAY_CNT-1:0] w_pick_way;

  assign w_same_set = bus.hit_valid_i && (bus.hit_set_i == bus.fill_set_i);
  assign w_hit_cur  = r_state[bus.hit_set_i];
  // Same-set fill builds on the hit result so the filled way ends up MRU.
  assign w_fill_cur = w_same_set ? w_hit_new : r_state[bus.fill_set_i];

  tree_lru_update #(
    .WAY_CNT (WAY_CNT)
  ) u_hit_upd (
    .i_tree  (w_hit_cur),
    .i_valid (bus.hit_valid_i),
    .i_way   (bus.hit_way_i),
    .o_tree  (w_hit_new)
  );

  tree_lru_update #(
    .WAY_CNT (WAY_CNT)
  ) u_fill_upd (
    .i_tree  (w_fill_cur),
    .i_valid (bus.fill_valid_i),
    .i_way   (bus.fill_way_i),
    .o_tree  (w_fill_new)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SET_CNT; s++) begin
        r_state[s] <= '0;
      end
      r_lkp_valid <= 1'b0;
      r_lkp_set   <= '0;
    end else begin
      if (bus.hit_valid_i && !(bus.fill_valid_i && w_same_set)) begin
        r_state[bus.hit_set_i] <= w_hit_new;
      end
      if (bus.fill_valid_i) begin
        r_state[bus.fill_set_i] <= w_fill_new;
      end
      r_lkp_valid <= bus.lookup_valid_i;
      r_lkp_set   <= bus.lookup_set_i;
    end
  end

  // Read after the capture edge, so touches from the lookup cycle are already in the array.
  assign w_lkp_tree = r_state[r_lkp_set];

  for (genvar w = 0; w < WAY_CNT; w++) begin : g_walk
    localparam tree_t PathMask = path_mask(w);
    localparam tree_t DirBits  = dir_bits(w);
    assign w_walk_way[w] = (((w_lkp_tree ^ DirBits) & PathMask) == '0);
  end

`ifdef PLRU_INVALID_FIRST_EN
  logic [WAY_CNT-1:0] r_way_valid;
  logic [WAY_CNT-1:0] w_inv;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_way_valid <= '1;
    end else if (bus.lookup_valid_i) begin
      r_way_valid <= bus.way_valid_i;
    end
  end

  assign w_inv      = ~r_way_valid;
  // Isolate the lowest set bit of the invalid mask.
  assign w_pick_way = (w_inv == '0) ? w_walk_way
                    : (w_inv & (~w_inv + {{(WAY_CNT-1){1'b0}}, 1'b1}));
`else
  logic w_unused_way_valid;
  assign w_unused_way_valid = ^bus.way_valid_i;
  assign w_pick_way         = w_walk_way;
`endif

  assign bus.victim_valid_o = r_lkp_valid;
  assign bus.victim_way_o   = r_lkp_valid ? w_pick_way : '0;
endmodule
